interval_checker: RTL
=====================

INTERVAL_CHECKER -- requirements
Module: interval_checker

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 4, width of the monitored data.
REQ-002 The block SHALL have parameter MIN_DLY, default 3, minimum allowed update gap in cycles (at least 1).
REQ-003 The block SHALL have parameter MAX_DLY, default 15, maximum allowed update gap in cycles (at least MIN_DLY, and less than 2**CNT_W).
REQ-004 The block SHALL have parameter EXP_VAL, default 4'h5, required data value on every update.
REQ-005 The block SHALL have parameter NUM_UPD, default 4, number of good updates required to pass (at least 1).
REQ-006 The block SHALL have parameter CNT_W, default 8, gap-counter width.
Ports:
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 The block SHALL have port start, input, 1: arm/restart the check.
REQ-010 The block SHALL have port upd, input, 1: one-cycle strobe marking a writer update.
REQ-011 The block SHALL have port upd_data, input, WIDTH: value written, sampled when upd=1.
REQ-012 The block SHALL have port busy, output, 1: high in ARMED or RUN.
REQ-013 The block SHALL have port pass, output, 1: high in PASS.
REQ-014 The block SHALL have port err_early, output, 1: sticky, an update arrived with gap < MIN_DLY.
REQ-015 The block SHALL have port err_late, output, 1: sticky, no update within MAX_DLY cycles.
REQ-016 The block SHALL have port err_data, output, 1: sticky, upd_data != EXP_VAL on an update.
REQ-017 The block SHALL have port upd_count, output, 4: good updates since start, saturating at 15.

Function
REQ-018 The FSM SHALL have the states IDLE, ARMED, RUN, PASS and FAIL; all outputs SHALL be registered.
REQ-019 start=1 in any state SHALL, at the next edge:
- enter ARMED;
- clear the gap counter, upd_count and all err flags;
- ignore upd on that same edge.
REQ-020 In ARMED and RUN, the gap counter SHALL clear on an accepted upd and otherwise increment by 1 per cycle.
REQ-021 Gap definition: gap = counter + 1, i.e. the number of edges since the start edge or the previous accepted upd edge.
REQ-022 On an upd edge in ARMED or RUN:
- gap < MIN_DLY SHALL set err_early;
- upd_data != EXP_VAL SHALL set err_data;
- either error SHALL take the FSM to FAIL;
- both errors MAY set on the same edge.
REQ-023 Otherwise a good update SHALL increment upd_count and move ARMED to RUN.
REQ-024 On the good update that makes upd_count equal NUM_UPD, the FSM SHALL enter PASS.
REQ-025 Boundary: gap == MIN_DLY and gap == MAX_DLY SHALL both be legal.
REQ-026 With no upd while counter == MAX_DLY-1 in ARMED or RUN, the block SHALL set err_late and enter FAIL on that edge; the counter never exceeds MAX_DLY-1.
REQ-027 In IDLE, PASS and FAIL, upd SHALL be ignored, the counter SHALL hold, and the flags SHALL hold.
REQ-028 Output decode:
- busy = 1 in ARMED or RUN;
- pass = 1 only in PASS;
- pass and any err flag SHALL never be high together.
REQ-029 upd_count SHALL saturate at 15 and not wrap (relevant only when NUM_UPD > 15, where PASS is unreachable).

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk:
- force IDLE;
- clear the counter and upd_count;
- clear busy, pass and all err flags.
REQ-031 Reset asserted mid-check SHALL abort the check; no flag survives.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-033 Nominal: start, then upd with data 5 at gaps 10,10,10,10 -> busy is 1 through the 4th update edge, then pass=1, upd_count=4, no err.
REQ-034 Bounds: start, then upd gaps 3,15,3,15 with data 5 -> pass=1; gap 2 instead -> err_early=1, FAIL, pass=0.
REQ-035 Late: start with no upd -> err_late=1 at the 15th edge after start, busy=0, upd_count=0.
REQ-036 Data: start, then upd at gap 5 with data 4'hA -> err_data=1, err_early=0, FAIL.
REQ-037 Restart: err_late set, then start -> all flags clear and busy=1 on the next edge; an upd on the start edge is ignored (no count, no error).
REQ-038 Reset: rst_n pulsed low between clock edges during RUN with upd_count=2 -> all outputs 0 before the next edge, and the block stays in IDLE until start.

Source files
------------

// File: rtl/interval_checker.sv
// rtl/interval_checker.sv - watches a writer's update strobe for gap, value and count violations
// Registered FSM: IDLE -> ARMED -> RUN -> PASS/FAIL, restarted by start at any time.
module interval_checker #(
   parameter int                WIDTH   = 4,
   parameter int                MIN_DLY = 3,
   parameter int                MAX_DLY = 15,
   parameter logic [WIDTH-1:0]  EXP_VAL = WIDTH'(4'h5),
   parameter int                NUM_UPD = 4,
   parameter int                CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             upd,
   input  logic [WIDTH-1:0] upd_data,
   output logic             busy,
   output logic             pass,
   output logic             err_early,
   output logic             err_late,
   output logic             err_data,
   output logic [3:0]       upd_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_PASS  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   localparam logic [CNT_W:0]   MIN_GAP  = (CNT_W+1)'(MIN_DLY);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DLY - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W:0]   gap;
   logic [3:0]       ucnt_nxt;
   logic             early_nxt, late_nxt, data_nxt, busy_nxt, pass_nxt;
   logic             active, early, bad, late, hit;

   // Gap counts edges since the start edge or the last accepted update edge.
   assign active = (state == S_ARMED) || (state == S_RUN);
   assign gap    = {1'b0, cnt} + (CNT_W+1)'(1);
   assign early  = gap < MIN_GAP;
   assign bad    = upd_data != EXP_VAL;
   assign late   = cnt == LAST_CNT;
   assign hit    = (upd_count != 4'hF) && ((int'(upd_count) + 1) == NUM_UPD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         upd_count <= '0;
         err_early <= 1'b0;
         err_late  <= 1'b0;
         err_data  <= 1'b0;
         busy      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         upd_count <= ucnt_nxt;
         err_early <= early_nxt;
         err_late  <= late_nxt;
         err_data  <= data_nxt;
         busy      <= busy_nxt;
         pass      <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_ARMED;
      end else if (active) begin
         if (upd) begin
            if (early || bad)
               state_nxt = S_FAIL;
            else if (hit)
               state_nxt = S_PASS;
            else
               state_nxt = S_RUN;
         end else if (late) begin
            state_nxt = S_FAIL;
         end
      end
   end

   // An update at counter == MAX_DLY-1 is a legal gap and wins over the late check.
   always_comb begin
      cnt_nxt   = cnt;
      ucnt_nxt  = upd_count;
      early_nxt = err_early;
      late_nxt  = err_late;
      data_nxt  = err_data;
      if (start) begin
         cnt_nxt   = '0;
         ucnt_nxt  = '0;
         early_nxt = 1'b0;
         late_nxt  = 1'b0;
         data_nxt  = 1'b0;
      end else if (active) begin
         if (upd) begin
            cnt_nxt   = '0;
            early_nxt = err_early | early;
            data_nxt  = err_data | bad;
            if (!early && !bad && (upd_count != 4'hF))
               ucnt_nxt = upd_count + 4'd1;
         end else if (late) begin
            late_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
      busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_RUN);
      pass_nxt = state_nxt == S_PASS;
   end

endmodule
